time_display_scanner: RTL and testbench
=======================================

Name: time_display_scanner

Overview:
Reads the BCD time digits produced by the timekeeping block (hours tens/units, minutes tens/units) and drives a 4-digit, common-anode, time-multiplexed seven-segment display as HH.MM. In adjust mode it blinks the field being set (hours or minutes). It also blinks the centre decimal point as a 1 Hz seconds indicator in normal mode. It is the display-side consumer of the time digit bus and sits between the time core and the board pins.

Parameters:
SCAN_DIV, 100000, clocks per digit slot (100 MHz gives 1 kHz per digit, 250 Hz refresh); minimum 2
BLINK_DIV, 50000000, clocks per blink half-period (0.5 s at 100 MHz); minimum 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
H1  in  2  hours tens digit (0-2)
H2  in  4  hours units digit (0-9)
M1  in  3  minutes tens digit (0-5)
M2  in  4  minutes units digit (0-9)
adjust  in  1  1 = adjust mode (selected field blinks)
sel_min  in  1  in adjust mode: 0 = hours field selected, 1 = minutes field selected
an  out  4  digit anodes, active-low; an[3] leftmost (H1), an[0] rightmost (M2)
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low

Behaviour:
- Single clock domain.
- Reset is synchronous, active-high, and applies on any clk edge with rst=1, including mid-scan. Reset values:
  - scan prescaler = 0, idx = 0
  - blink prescaler = 0, phase = 0
  - an = 4'b1111, seg = 7'b1111111, dp = 1
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx advances 0→1→2→3→0.
- Digit mapping:
  - idx0 → M2 on an[0]
  - idx1 → M1 on an[1]
  - idx2 → H2 on an[2]
  - idx3 → H1 on an[3]
- Blink prescaler:
  - Counts 0..BLINK_DIV-1.
  - On wrap, phase toggles.
  - A 0→1 transition of adjust (detected against a registered copy of adjust) clears the blink prescaler and phase to 0, so the selected field is visible for a full half-period first.
- Outputs are registered, with one-cycle latency from idx, input digits, adjust, sel_min or phase to an/seg/dp.
- Anode: exactly one bit low, the bit for the current idx. All anodes are forced high (blanked) when adjust=1, phase=1 and the current idx belongs to the selected field:
  - sel_min=0 blanks idx 2 and 3.
  - sel_min=1 blanks idx 0 and 1.
- Segment decode (digit → seg):
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10-15 → 1111111 (blank; covers illegal BCD)
- Width rules: H1 and M1 are zero-extended to 4 bits before decoding. No leading-zero suppression; 00:00 shows "00.00".
- Decimal point:
  - Active only when idx=2 (between hours and minutes).
  - Normal mode: dp=0 when phase=0, else 1.
  - Adjust mode: dp=0 steadily.
  - dp=1 for every other idx.
  - dp is not blanked by field blinking.
- Input changes mid-slot take effect on the next clock; there is no sampling per slot.
- adjust falling: blanking stops on the next registered output. phase continues free-running.

Test Plan:
All scenarios use SCAN_DIV=4 and BLINK_DIV=32.
1. Reset: assert rst for 3 cycles mid-scan → an=1111, seg=1111111 and dp=1 during reset; first output after release shows an=1110 with M2's pattern.
2. Scan order: H1=1, H2=2, M1=3, M2=4, adjust=0 → an/seg sequence 1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001, each held 4 cycles, then repeating.
3. Decode sweep: drive M2 = 0..15 → seg matches the table; 10-15 give 1111111.
4. Colon: adjust=0 → dp=0 at idx2 while phase=0, dp=1 at idx2 while phase=1 (toggle every 32 cycles), dp=1 at all other idx.
5. Hours blink: adjust 0→1 with sel_min=0 → an[3:2] pulse for the first 32 cycles after the edge, then stay 11 for 32 cycles while an[1:0] keep scanning; dp=0 steadily at idx2. Switching to sel_min=1 moves blanking to an[1:0] on the next cycle.
6. Adjust re-entry: toggle adjust 1→0→1 while phase=1 → phase clears to 0 on re-entry and the selected field is visible for the next 32 cycles.

Source files
------------

// File: rtl/time_display_scanner_if.sv
// Time digit bus from the timekeeping core plus the multiplexed display pins.
// The time core is the master of the digits; the scanner (slave) drives the display.
interface time_display_scanner_if;
  logic [1:0] H1;
  logic [3:0] H2;
  logic [2:0] M1;
  logic [3:0] M2;
  logic       adjust;
  logic       sel_min;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output H1, H2, M1, M2, adjust, sel_min,
    input  an, seg, dp
  );

  modport slave (
    input  H1, H2, M1, M2, adjust, sel_min,
    output an, seg, dp
  );
endinterface

// File: rtl/time_display_scanner.sv
// 4-digit common-anode HH.MM scanner with field blinking in adjust mode and a
// 1 Hz seconds dot on the centre digit in normal mode.
module time_display_scanner #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic                   clk,
  input  logic                   rst,
  time_display_scanner_if.slave  disp
);

  localparam int unsigned SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          adj_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          adj_rise;
  logic          phase_eff;
  logic [3:0]    digit;
  logic          blank;

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 1'b1;
    end

    // Entering adjust restarts the blink so the selected field is shown first;
    // the cleared phase is also used for this cycle's output.
    adj_rise    = disp.adjust & ~adj_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    if (adj_rise) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end
    phase_eff = phase_q & ~adj_rise;

    unique case (idx_q)
      2'd0:    digit = disp.M2;
      2'd1:    digit = {1'b0, disp.M1};
      2'd2:    digit = disp.H2;
      default: digit = {2'b00, disp.H1};
    endcase

    unique case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase

    // idx[1] splits the display into minutes (0,1) and hours (2,3)
    blank = disp.adjust & phase_eff & (disp.sel_min ? ~idx_q[1] : idx_q[1]);
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);

    dp_d = 1'b1;
    if (idx_q == 2'd2) dp_d = disp.adjust ? 1'b0 : phase_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      adj_q       <= 1'b0;
      an_q        <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      adj_q       <= disp.adjust;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// Directed bench for time_display_scanner with SCAN_DIV=4, BLINK_DIV=32.
module tb_time_display_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  time_display_scanner_if tdi ();

  time_display_scanner #(.SCAN_DIV(4), .BLINK_DIV(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (tdi.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] m2;
    logic [6:0] seg;
  } dec_vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } scan_vec_t;

  dec_vec_t  dec_tab  [16];
  scan_vec_t scan_tab [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int k);
    while (n < k) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("reset_an",  {28'd0, tdi.an},  32'hF);
      chk("reset_seg", {25'd0, tdi.seg}, 32'h7F);
      chk("reset_dp",  {31'd0, tdi.dp},  32'h1);
    end
    rst = 1'b0;
    n   = 0;
  endtask

  initial begin
    dec_tab[0]  = '{4'd0,  7'b1000000};
    dec_tab[1]  = '{4'd1,  7'b1111001};
    dec_tab[2]  = '{4'd2,  7'b0100100};
    dec_tab[3]  = '{4'd3,  7'b0110000};
    dec_tab[4]  = '{4'd4,  7'b0011001};
    dec_tab[5]  = '{4'd5,  7'b0010010};
    dec_tab[6]  = '{4'd6,  7'b0000010};
    dec_tab[7]  = '{4'd7,  7'b1111000};
    dec_tab[8]  = '{4'd8,  7'b0000000};
    dec_tab[9]  = '{4'd9,  7'b0010000};
    dec_tab[10] = '{4'd10, 7'b1111111};
    dec_tab[11] = '{4'd11, 7'b1111111};
    dec_tab[12] = '{4'd12, 7'b1111111};
    dec_tab[13] = '{4'd13, 7'b1111111};
    dec_tab[14] = '{4'd14, 7'b1111111};
    dec_tab[15] = '{4'd15, 7'b1111111};

    // H1=1, H2=2, M1=3, M2=4
    scan_tab[0] = '{4'b1110, 7'b0011001};
    scan_tab[1] = '{4'b1101, 7'b0110000};
    scan_tab[2] = '{4'b1011, 7'b0100100};
    scan_tab[3] = '{4'b0111, 7'b1111001};

    tdi.H1 = 2'd1; tdi.H2 = 4'd2; tdi.M1 = 3'd3; tdi.M2 = 4'd4;
    tdi.adjust = 1'b0; tdi.sel_min = 1'b0;

    // Scan order: each slot held 4 cycles, two full rounds
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("scan_an",  {28'd0, tdi.an},  {28'd0, scan_tab[((k - 1) / 4) % 4].an});
      chk("scan_seg", {25'd0, tdi.seg}, {25'd0, scan_tab[((k - 1) / 4) % 4].seg});
    end

    // Seconds dot, normal mode
    do_reset();
    step_to(1);  chk("dp_idx0", {31'd0, tdi.dp}, 32'h1);
    step_to(5);  chk("dp_idx1", {31'd0, tdi.dp}, 32'h1);
    step_to(9);  chk("dp_idx2_ph0_an", {28'd0, tdi.an}, 32'hB);
                 chk("dp_idx2_ph0", {31'd0, tdi.dp}, 32'h0);
    step_to(12); chk("dp_idx2_ph0_end", {31'd0, tdi.dp}, 32'h0);
    step_to(13); chk("dp_idx3", {31'd0, tdi.dp}, 32'h1);
    step_to(41); chk("dp_idx2_ph1_an", {28'd0, tdi.an}, 32'hB);
                 chk("dp_idx2_ph1", {31'd0, tdi.dp}, 32'h1);
    step_to(44); chk("dp_idx2_ph1_end", {31'd0, tdi.dp}, 32'h1);
    step_to(73); chk("dp_idx2_ph0_again", {31'd0, tdi.dp}, 32'h0);

    // Reset mid-scan, then first output is M2 on an[0]
    step_to(74);
    do_reset();
    tick();
    chk("post_reset_an",  {28'd0, tdi.an},  32'hE);
    chk("post_reset_seg", {25'd0, tdi.seg}, {25'd0, 7'b0011001});

    // Decode sweep on M2
    for (int i = 0; i < 16; i++) begin
      tdi.M2 = dec_tab[i].m2;
      do_reset();
      tick();
      chk("dec_an",  {28'd0, tdi.an},  32'hE);
      chk($sformatf("dec_seg_%0d", i), {25'd0, tdi.seg}, {25'd0, dec_tab[i].seg});
    end
    tdi.M2 = 4'd4;

    // Hours blink: adjust rises before edge 6, phase=1 outputs on edges 39..70
    do_reset();
    step_to(5);
    tdi.adjust = 1'b1; tdi.sel_min = 1'b0;
    step_to(9);  chk("hb_idx2_vis", {28'd0, tdi.an}, 32'hB);
                 chk("hb_dp_adj",   {31'd0, tdi.dp}, 32'h0);
    step_to(13); chk("hb_idx3_vis", {28'd0, tdi.an}, 32'h7);
    step_to(37); chk("hb_idx1_ph0", {28'd0, tdi.an}, 32'hD);
    step_to(41); chk("hb_idx2_blank", {28'd0, tdi.an}, 32'hF);
                 chk("hb_dp_not_blanked", {31'd0, tdi.dp}, 32'h0);
    step_to(45); chk("hb_idx3_blank", {28'd0, tdi.an}, 32'hF);
    step_to(49); chk("hb_idx0_scan", {28'd0, tdi.an}, 32'hE);
    step_to(53); chk("hb_idx1_scan", {28'd0, tdi.an}, 32'hD);
    tdi.sel_min = 1'b1;
    step_to(54); chk("mb_idx1_blank", {28'd0, tdi.an}, 32'hF);
    step_to(57); chk("mb_idx2_vis", {28'd0, tdi.an}, 32'hB);
    step_to(73); chk("mb_idx2_ph0", {28'd0, tdi.an}, 32'hB);
    step_to(81); chk("mb_idx0_ph0", {28'd0, tdi.an}, 32'hE);

    // Re-entry during phase=1 (outputs on edges 103..134 would be blank)
    step_to(113); chk("re_idx0_blank", {28'd0, tdi.an}, 32'hF);
    tdi.adjust = 1'b0;
    step_to(114); chk("re_exit_vis", {28'd0, tdi.an}, 32'hE);
                  chk("re_exit_dp",  {31'd0, tdi.dp}, 32'h1);
    tdi.adjust = 1'b1;
    step_to(116); chk("re_entry_vis", {28'd0, tdi.an}, 32'hE);
    step_to(121); chk("re_idx2_vis", {28'd0, tdi.an}, 32'hB);
                  chk("re_idx2_dp",  {31'd0, tdi.dp}, 32'h0);
    step_to(129); chk("re_idx0_cleared", {28'd0, tdi.an}, 32'hE);
    step_to(145); chk("re_idx0_late", {28'd0, tdi.an}, 32'hE);
    step_to(149); chk("re_idx1_blank", {28'd0, tdi.an}, 32'hF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
